// File: rtl/cpu_mmu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mmu_pkg
// Description : Shared types and constants for the MMU cache fill sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_mmu_pkg;

    localparam int CA_W          = 11;
    localparam int CPN_W         = 14;
    localparam int MADDR_W       = 24;
    localparam int DATA_W        = 16;
    localparam int TMO_W         = 8;
    localparam int TMO_CYC_DEF   = 255;
    localparam int N_ENTRIES_DEF = 2048;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_MREQ  = 3'd2,
        ST_UPD   = 3'd3,
        ST_DONE  = 3'd4
    } mmu_fill_state_e;

    // Word address on the memory bus: page number above the in-page index.
    function automatic logic [MADDR_W-1:0] mem_word_addr(
        input logic [CPN_W-1:0] ppn,
        input logic [CA_W-1:0]  ca
    );
        return {ppn, ca[9:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_mmu_fill_tmo.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mmu_fill_tmo
// Description : 8-bit memory-ack timeout counter with clear, enable and an
//               expire flag raised in the last allowed waiting cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_mmu_fill_tmo
    import cpu_mmu_pkg::*;
#(
    parameter int TMO_CYC = TMO_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam logic [TMO_W-1:0] c_last = TMO_W'(TMO_CYC - 1);

    logic [TMO_W-1:0] r_cnt;

    // Count waiting cycles; the count is zero in the first waiting cycle.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + TMO_W'(1);
        end
    end

    // Expire in the cycle whose increment would reach the limit, so the
    // requester waits exactly TMO_CYC cycles.
    assign o_expire = i_en && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/cpu_mmu_fill_seq.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mmu_fill_seq
// Description : Drives the MMU cache write/tag port. Sweeps the cache invalid
//               on clear, fills on read miss, writes through on CPU writes and
//               updates the line on a write hit.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_mmu_fill_seq
    import cpu_mmu_pkg::*;
#(
    parameter int N_ENTRIES = N_ENTRIES_DEF,
    parameter int TMO_CYC   = TMO_CYC_DEF
) (
    input  logic               sysclk,
    input  logic               sys_rst,
    input  logic               CON,
    input  logic               CCLR,
    input  logic               ACC_REQ,
    input  logic               WRITE,
    input  logic               HIT,
    input  logic [CA_W-1:0]    CA_IN,
    input  logic [CPN_W-1:0]   PPN_IN,
    input  logic [DATA_W-1:0]  WDATA,
    input  logic               MEM_ACK,
    input  logic               MEM_ERR,
    input  logic [DATA_W-1:0]  MEM_RDATA,
    output logic               MEM_REQ,
    output logic               MEM_WE,
    output logic [MADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0]  MEM_WDATA,
    output logic               CWR,
    output logic [CA_W-1:0]    CA_OUT,
    output logic [DATA_W-1:0]  CD_OUT,
    output logic [CPN_W-1:0]   CPN_OUT,
    output logic               CVLD_OUT,
    output logic               FMISS,
    output logic               BUSY,
    output logic               ACC_DONE,
    output logic [DATA_W-1:0]  RDATA,
    output logic               ACC_ERR
);

    localparam logic [CA_W-1:0] c_last_idx = CA_W'(N_ENTRIES - 1);

    mmu_fill_state_e    r_state;
    mmu_fill_state_e    w_state_nxt;
    logic [CA_W-1:0]    r_idx;
    logic [CA_W-1:0]    w_idx_nxt;
    logic               r_clr_pend;

    logic [CA_W-1:0]    r_ca;
    logic [CPN_W-1:0]   r_ppn;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_rdata;
    logic               r_hit;
    logic               r_write;
    logic               r_err;

    logic               w_clr_req;
    logic               w_accept;
    logic               w_tmo_expire;
    logic               w_upd_wr;

    assign w_clr_req = CCLR || r_clr_pend;
    assign w_accept  = (r_state == ST_IDLE) && !w_clr_req && ACC_REQ;
    // Fill on a read miss, update only on a write hit; write misses never allocate.
    assign w_upd_wr  = CON && (!r_write || r_hit);

    cpu_mmu_fill_tmo #(
        .TMO_CYC (TMO_CYC)
    ) u_tmo (
        .clk      (sysclk),
        .rst      (sys_rst),
        .i_clr    (r_state != ST_MREQ),
        .i_en     (r_state == ST_MREQ),
        .o_expire (w_tmo_expire)
    );

    // State and sweep-index register; reset always lands in a fresh sweep.
    always_ff @(posedge sysclk) begin
        if (sys_rst) begin
            r_state <= ST_CLEAR;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Clear requests arriving mid-access wait here until the access finishes.
    always_ff @(posedge sysclk) begin
        if (sys_rst) begin
            r_clr_pend <= 1'b0;
        end else if (w_state_nxt == ST_CLEAR) begin
            r_clr_pend <= 1'b0;
        end else if (CCLR) begin
            r_clr_pend <= 1'b1;
        end
    end

    // Capture the access on acceptance and the bus result on ack/timeout.
    always_ff @(posedge sysclk) begin
        if (sys_rst) begin
            r_ca    <= '0;
            r_ppn   <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_hit   <= 1'b0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_ca    <= CA_IN;
            r_ppn   <= PPN_IN;
            r_wdata <= WDATA;
            r_rdata <= '0;
            r_hit   <= HIT;
            r_write <= WRITE;
            r_err   <= 1'b0;
        end else if (r_state == ST_MREQ) begin
            if (MEM_ACK) begin
                r_err <= MEM_ERR;
                if (!MEM_ERR) begin
                    r_rdata <= MEM_RDATA;
                end
            end else if (w_tmo_expire) begin
                r_err <= 1'b1;
            end
        end
    end

    // Next-state, next-index and Moore outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        MEM_REQ     = 1'b0;
        MEM_WE      = 1'b0;
        MEM_ADDR    = '0;
        MEM_WDATA   = '0;
        CWR         = 1'b0;
        CA_OUT      = '0;
        CD_OUT      = '0;
        CPN_OUT     = '0;
        CVLD_OUT    = 1'b0;
        FMISS       = 1'b0;
        BUSY        = 1'b1;
        ACC_DONE    = 1'b0;
        RDATA       = '0;
        ACC_ERR     = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                BUSY = 1'b0;
                if (w_clr_req) begin
                    w_state_nxt = ST_CLEAR;
                    w_idx_nxt   = '0;
                end else if (ACC_REQ) begin
                    w_state_nxt = (!WRITE && CON && HIT) ? ST_DONE : ST_MREQ;
                end
            end
            ST_CLEAR: begin
                // Strobe is held off while reset is asserted.
                CWR    = !sys_rst;
                CA_OUT = r_idx;
                FMISS  = 1'b1;
                if (CCLR) begin
                    w_idx_nxt = '0;
                end else if (r_idx == c_last_idx) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_idx_nxt = r_idx + CA_W'(1);
                end
            end
            ST_MREQ: begin
                MEM_REQ   = 1'b1;
                MEM_WE    = r_write;
                MEM_ADDR  = mem_word_addr(r_ppn, r_ca);
                MEM_WDATA = r_wdata;
                // An ack coinciding with the timeout still wins.
                if (MEM_ACK) begin
                    w_state_nxt = MEM_ERR ? ST_DONE : ST_UPD;
                end else if (w_tmo_expire) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_UPD: begin
                if (w_upd_wr) begin
                    CWR      = 1'b1;
                    CA_OUT   = r_ca;
                    CD_OUT   = r_write ? r_wdata : r_rdata;
                    CPN_OUT  = r_ppn;
                    CVLD_OUT = 1'b1;
                end
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                ACC_DONE = 1'b1;
                ACC_ERR  = r_err;
                RDATA    = r_write ? '0 : r_rdata;
                if (w_clr_req) begin
                    w_state_nxt = ST_CLEAR;
                    w_idx_nxt   = '0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_CLEAR;
                w_idx_nxt   = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_mmu_fill_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_mmu_fill_seq
// Description : Directed self-checking bench for cpu_mmu_fill_seq.
//               Inputs change and outputs are sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_mmu_fill_seq;

    localparam int N = 2048;

    logic        sysclk = 1'b0;
    logic        sys_rst, CON, CCLR, ACC_REQ, WRITE, HIT;
    logic [10:0] CA_IN;
    logic [13:0] PPN_IN;
    logic [15:0] WDATA, MEM_RDATA;
    logic        MEM_ACK, MEM_ERR;
    logic        MEM_REQ, MEM_WE, CWR, CVLD_OUT, FMISS, BUSY, ACC_DONE, ACC_ERR;
    logic [23:0] MEM_ADDR;
    logic [15:0] MEM_WDATA, CD_OUT, RDATA;
    logic [10:0] CA_OUT;
    logic [13:0] CPN_OUT;

    int n_vec = 0;
    int n_mis = 0;

    cpu_mmu_fill_seq dut (
        .sysclk(sysclk), .sys_rst(sys_rst), .CON(CON), .CCLR(CCLR),
        .ACC_REQ(ACC_REQ), .WRITE(WRITE), .HIT(HIT), .CA_IN(CA_IN),
        .PPN_IN(PPN_IN), .WDATA(WDATA), .MEM_ACK(MEM_ACK), .MEM_ERR(MEM_ERR),
        .MEM_RDATA(MEM_RDATA), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE),
        .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .CWR(CWR),
        .CA_OUT(CA_OUT), .CD_OUT(CD_OUT), .CPN_OUT(CPN_OUT),
        .CVLD_OUT(CVLD_OUT), .FMISS(FMISS), .BUSY(BUSY),
        .ACC_DONE(ACC_DONE), .RDATA(RDATA), .ACC_ERR(ACC_ERR)
    );

    always #5 sysclk = ~sysclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic nclk();
        @(negedge sysclk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expect N consecutive invalidating writes at indices 0..N-1, then idle.
    task automatic sweep(input string tag);
        int bad = 0;
        #1;
        for (int i = 0; i < N; i++) begin
            if (!(CWR === 1'b1 && CA_OUT === 11'(i) && CVLD_OUT === 1'b0 &&
                  CD_OUT === 16'h0 && CPN_OUT === 14'h0 && BUSY === 1'b1 && FMISS === 1'b1))
                bad++;
            nclk();
        end
        chk({tag, "_sweep_bad_cycles"}, bad, 0);
        chk({tag, "_busy_after"}, BUSY, 0);
        chk({tag, "_cwr_after"}, CWR, 0);
    endtask

    task automatic req(input logic wr, input logic hit, input logic [10:0] ca,
                       input logic [13:0] ppn, input logic [15:0] wd);
        ACC_REQ = 1'b1; WRITE = wr; HIT = hit; CA_IN = ca; PPN_IN = ppn; WDATA = wd;
    endtask

    task automatic ack(input logic err, input logic [15:0] d);
        MEM_ACK = 1'b1; MEM_ERR = err; MEM_RDATA = d;
        nclk();
        MEM_ACK = 1'b0; MEM_ERR = 1'b0; MEM_RDATA = 16'h0;
    endtask

    initial begin
        int n;
        int cwr_seen;
        sys_rst = 1'b1; CON = 1'b1; CCLR = 1'b0; ACC_REQ = 1'b0; WRITE = 1'b0;
        HIT = 1'b0; CA_IN = '0; PPN_IN = '0; WDATA = '0;
        MEM_ACK = 1'b0; MEM_ERR = 1'b0; MEM_RDATA = '0;
        repeat (3) nclk();

        // Reset state
        chk("rst_busy", BUSY, 1);
        chk("rst_fmiss", FMISS, 1);
        chk("rst_cwr", CWR, 0);
        chk("rst_memreq", MEM_REQ, 0);
        chk("rst_done", ACC_DONE, 0);
        chk("rst_ca", CA_OUT, 0);

        sys_rst = 1'b0;
        sweep("post_reset");

        // Read miss fill: ack after 5 MREQ cycles
        req(0, 0, 11'h123, 14'h0ABC, 16'h0);
        nclk();
        chk("rm_memreq", MEM_REQ, 1);
        chk("rm_memwe", MEM_WE, 0);
        chk("rm_addr", MEM_ADDR, 24'h2AF123);
        CA_IN = 11'h7FF; PPN_IN = 14'h3FFF; HIT = 1'b1;
        repeat (4) nclk();
        chk("rm_addr_held", MEM_ADDR, 24'h2AF123);
        ack(0, 16'hBEEF);
        chk("rm_cwr", CWR, 1);
        chk("rm_cd", CD_OUT, 16'hBEEF);
        chk("rm_cpn", CPN_OUT, 14'h0ABC);
        chk("rm_cvld", CVLD_OUT, 1);
        chk("rm_ca", CA_OUT, 11'h123);
        chk("rm_memreq_low", MEM_REQ, 0);
        nclk();
        chk("rm_done", ACC_DONE, 1);
        chk("rm_rdata", RDATA, 16'hBEEF);
        chk("rm_err", ACC_ERR, 0);
        chk("rm_cwr_once", CWR, 0);
        ACC_REQ = 1'b0;
        nclk();
        chk("rm_done_pulse", ACC_DONE, 0);
        chk("rm_idle", BUSY, 0);

        // Read hit: one-cycle latency, no memory access
        req(0, 1, 11'h010, 14'h0001, 16'h0);
        nclk();
        chk("rh_done", ACC_DONE, 1);
        chk("rh_rdata", RDATA, 0);
        chk("rh_memreq", MEM_REQ, 0);
        ACC_REQ = 1'b0;
        nclk();

        // Write hit: write-through plus line update
        req(1, 1, 11'h045, 14'h1234, 16'h5555);
        nclk();
        chk("wh_memreq", MEM_REQ, 1);
        chk("wh_memwe", MEM_WE, 1);
        chk("wh_wdata", MEM_WDATA, 16'h5555);
        chk("wh_addr", MEM_ADDR, 24'h48D045);
        ack(0, 16'h0);
        chk("wh_cwr", CWR, 1);
        chk("wh_cd", CD_OUT, 16'h5555);
        chk("wh_ca", CA_OUT, 11'h045);
        chk("wh_cpn", CPN_OUT, 14'h1234);
        nclk();
        chk("wh_done", ACC_DONE, 1);
        ACC_REQ = 1'b0;
        nclk();

        // Write miss: memory only, no allocate
        req(1, 0, 11'h046, 14'h1234, 16'hAAAA);
        nclk();
        chk("wm_memwe", MEM_WE, 1);
        ack(0, 16'h0);
        chk("wm_no_cwr", CWR, 0);
        nclk();
        chk("wm_done", ACC_DONE, 1);
        chk("wm_err", ACC_ERR, 0);
        ACC_REQ = 1'b0;
        nclk();

        // No ack: timeout after 255 request cycles
        req(0, 0, 11'h200, 14'h0002, 16'h0);
        nclk();
        n = 0; cwr_seen = 0;
        while (MEM_REQ === 1'b1 && n < 400) begin
            n++;
            if (CWR === 1'b1) cwr_seen++;
            nclk();
        end
        chk("tmo_req_cycles", n, 255);
        chk("tmo_done", ACC_DONE, 1);
        chk("tmo_err", ACC_ERR, 1);
        chk("tmo_cwr", cwr_seen + int'(CWR), 0);
        ACC_REQ = 1'b0;
        nclk();

        // Bus error on ack
        req(0, 0, 11'h201, 14'h0002, 16'h0);
        nclk();
        nclk();
        ack(1, 16'hDEAD);
        chk("berr_done", ACC_DONE, 1);
        chk("berr_err", ACC_ERR, 1);
        chk("berr_cwr", CWR, 0);
        ACC_REQ = 1'b0;
        nclk();

        // Ack in the timeout cycle counts as an ack
        req(0, 0, 11'h202, 14'h0003, 16'h0);
        nclk();
        repeat (254) nclk();
        chk("tmo_edge_still_req", MEM_REQ, 1);
        ack(0, 16'h1357);
        chk("tmo_edge_cwr", CWR, 1);
        chk("tmo_edge_cd", CD_OUT, 16'h1357);
        chk("tmo_edge_not_done", ACC_DONE, 0);
        nclk();
        chk("tmo_edge_done", ACC_DONE, 1);
        chk("tmo_edge_err", ACC_ERR, 0);
        chk("tmo_edge_rdata", RDATA, 16'h1357);
        ACC_REQ = 1'b0;
        nclk();

        // CCLR during MREQ: fill completes, then sweep
        req(0, 0, 11'h300, 14'h0004, 16'h0);
        nclk();
        CCLR = 1'b1;
        nclk();
        CCLR = 1'b0;
        chk("pend_still_mreq", MEM_REQ, 1);
        chk("pend_fmiss", FMISS, 0);
        ack(0, 16'h2468);
        chk("pend_cwr", CWR, 1);
        chk("pend_cd", CD_OUT, 16'h2468);
        nclk();
        chk("pend_done", ACC_DONE, 1);
        chk("pend_rdata", RDATA, 16'h2468);
        ACC_REQ = 1'b0;
        nclk();
        chk("pend_clear_fmiss", FMISS, 1);
        sweep("pend");

        // CCLR at idx 1000 restarts the sweep
        CCLR = 1'b1;
        nclk();
        CCLR = 1'b0;
        chk("restart_start_ca", CA_OUT, 0);
        repeat (1000) nclk();
        chk("restart_at_1000", CA_OUT, 1000);
        CCLR = 1'b1;
        nclk();
        CCLR = 1'b0;
        chk("restart_ca0", CA_OUT, 0);
        chk("restart_cwr", CWR, 1);
        sweep("restart");

        // CON=0 read with HIT=1: memory read, no cache write
        CON = 1'b0;
        req(0, 1, 11'h0AA, 14'h0005, 16'h0);
        nclk();
        chk("con0_memreq", MEM_REQ, 1);
        ack(0, 16'h4242);
        chk("con0_no_cwr", CWR, 0);
        nclk();
        chk("con0_done", ACC_DONE, 1);
        chk("con0_rdata", RDATA, 16'h4242);
        ACC_REQ = 1'b0;
        CON = 1'b1;
        nclk();

        // Reset mid-operation aborts the access
        req(0, 0, 11'h0BB, 14'h0006, 16'h0);
        nclk();
        chk("abort_memreq_before", MEM_REQ, 1);
        sys_rst = 1'b1;
        nclk();
        chk("abort_memreq", MEM_REQ, 0);
        chk("abort_cwr", CWR, 0);
        chk("abort_busy", BUSY, 1);
        ACC_REQ = 1'b0;
        sys_rst = 1'b0;
        sweep("abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_mmu_fill_seq.md
Name: cpu_mmu_fill_seq

Overview:
Cache-side sequencer that drives the MMU cache write and tag port (CA, CD, CPN, CWR) instead of consuming it.
- Sweeps all cache entries to invalid on clear.
- On a read miss, fetches the word from the memory bus and writes data plus tag into the cache.
- On a write, performs a write-through and updates the cache line on a hit.
- Sits between the MMU top level and the memory bus interface on the CPU board.

Parameters:
- N_ENTRIES, 2048, number of cache entries swept on clear (CA width = log2).
- TMO_CYC, 255, memory-ack timeout in cycles (8-bit counter).

Ports:
- sysclk  in  1  system clock.
- sys_rst  in  1  synchronous reset, active-high.
- CON  in  1  cache enabled.
- CCLR  in  1  clear request pulse, active-high.
- ACC_REQ  in  1  CPU access request, level; held until ACC_DONE.
- WRITE  in  1  access is a write.
- HIT  in  1  cache hit for the current access; valid in any cycle ACC_REQ=1.
- CA_IN  in  11  cache index of the access.
- PPN_IN  in  14  physical page number [23:10] of the access.
- WDATA  in  16  CPU write data.
- MEM_ACK  in  1  memory-bus completion pulse.
- MEM_ERR  in  1  bus error, qualified by MEM_ACK.
- MEM_RDATA  in  16  memory read data, valid with MEM_ACK.
- MEM_REQ  out  1  memory request, level until MEM_ACK or timeout.
- MEM_WE  out  1  memory write.
- MEM_ADDR  out  24  word address {PPN_IN, CA_IN[9:0]}.
- MEM_WDATA  out  16  write data.
- CWR  out  1  cache write strobe, one cycle per write.
- CA_OUT  out  11  cache index written.
- CD_OUT  out  16  cache data written.
- CPN_OUT  out  14  tag written.
- CVLD_OUT  out  1  valid bit written.
- FMISS  out  1  force-miss while clearing.
- BUSY  out  1  not IDLE.
- ACC_DONE  out  1  one-cycle completion pulse.
- RDATA  out  16  read data, valid with ACC_DONE.
- ACC_ERR  out  1  with ACC_DONE: bus error or timeout.

Behaviour:
- States: IDLE, CLEAR, MREQ, UPD, DONE.
- Reset:
  - Every output is 0 except BUSY=1 and FMISS=1.
  - State is CLEAR with index 0; a full sweep always follows reset.
  - Reset mid-operation aborts: MEM_REQ drops in the next cycle and no CWR is issued.
- CLEAR:
  - One entry per cycle: CWR=1, CA_OUT=idx, CVLD_OUT=0, CD_OUT=0, CPN_OUT=0.
  - idx counts 0..N_ENTRIES-1, then IDLE; sweep takes exactly N_ENTRIES cycles.
  - CCLR during CLEAR restarts idx at 0.
  - ACC_REQ is not accepted during CLEAR.
- CCLR while busy in MREQ/UPD/DONE is latched pending; CLEAR starts the cycle after DONE.
- IDLE with ACC_REQ=1 (pending clear has priority over ACC_REQ):
  - Read, CON=1, HIT=1: go to DONE, RDATA=0 (data comes from the cache path). Latency 1 cycle.
  - Read with HIT=0 or CON=0: go to MREQ; MEM_REQ asserts the next cycle.
  - Write: go to MREQ with MEM_WE=1 (write-through).
  - Address, data and HIT are captured on acceptance; later changes are ignored.
- MREQ:
  - MEM_REQ held high; timeout counter increments.
  - MEM_ACK with MEM_ERR=0 goes to UPD.
  - MEM_ACK with MEM_ERR=1 goes to DONE with ACC_ERR=1 and no CWR.
  - Counter reaching TMO_CYC goes to DONE with ACC_ERR=1.
  - MEM_ACK in the same cycle as the timeout counts as an ack.
- UPD: issues CWR=1 exactly when one of these holds:
  - CON=1 and read miss: CD_OUT=MEM_RDATA, CPN_OUT=PPN, CVLD_OUT=1, CA_OUT=captured CA.
  - CON=1 and write with captured HIT=1: CD_OUT=WDATA, same tag/valid.
  - Write miss: no allocate, no CWR.
  - Then go to DONE.
- DONE: ACC_DONE=1 for one cycle; RDATA=MEM_RDATA for reads; then IDLE.
- Accept ordering: the requester drops ACC_REQ after ACC_DONE. If ACC_REQ is still high in IDLE, it is a new access.

Decomposition:
- Shared package cpu_mmu_pkg holds:
  - the state enum;
  - constants CA_W=11, CPN_W=14, MADDR_W=24;
  - TMO_CYC default.
- One sub-module, cpu_mmu_fill_tmo: 8-bit timeout counter with clear/enable and an expire flag.

Test Plan:
- Reset released → BUSY=1, 2048 consecutive CWR with CVLD_OUT=0 and CA_OUT 0..2047, then BUSY=0.
- Read with CON=1, HIT=0, CA=0x123, PPN=0x0ABC, ACK after 5 cycles with data 0xBEEF:
  - MEM_ADDR=0x2AF123;
  - one CWR with CD=0xBEEF, CPN=0x0ABC, CVLD=1;
  - ACC_DONE with RDATA=0xBEEF.
- Write hit with WDATA=0x5555 → MEM_WE=1, CWR with CD=0x5555. Write miss → memory write only, no CWR.
- Memory never acks → after 255 cycles ACC_DONE with ACC_ERR=1, no CWR. MEM_ERR on ack → same result.
- CCLR pulse during MREQ → fill completes and ACC_DONE fires, then a 2048-cycle sweep. CCLR at sweep idx=1000 → sweep restarts at 0.
- CON=0 read with HIT=1 → memory read still issued, no CWR, ACC_DONE carries memory data.
